apbgpio_pro: RTL

//  Parametrised APB GPIO port, successor to the fixed 32-bit GPIO. Per-pin direction,

---
 rtl/apbgpio_pro_if.sv | 12 +
 rtl/apbgpio_pro.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apbgpio_pro_if.sv
// APB slave bus bundle for the apbgpio_pro GPIO port (32-bit address/data, zero wait states).
interface apbgpio_pro_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (output paddr, psel, penable, pwrite, pwdata, input prdata);
  modport slave  (input paddr, psel, penable, pwrite, pwdata, output prdata);
endinterface

// File: rtl/apbgpio_pro.sv
// Parametrised APB GPIO: direction, atomic set/clr/tgl, per-pin edge/level IRQ, W1C status.
// Optional input debounce is compiled in with `define GPIO_DEBOUNCE_EN.

module apbgpio_pro_pin #(
  parameter int DB_STABLE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_i,
  input  logic dir_i,
  input  logic type_i,
  input  logic pol_i,
  input  logic both_i,
  input  logic db_en_i,
  input  logic tick_i,
  output logic filt_o,
  output logic hit_o
);
  logic sync1_q, sync2_q, prev_q;
  logic rise, fall, lvl, edg;

  // prev follows filt even while the pin drives, so DIR 1->0 never fakes an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
      prev_q  <= filt_o;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DB_STABLE + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (!db_en_i) begin
      filt_d = sync2_q;
      cnt_d  = '0;
    end else if (sync2_q == filt_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CW'(DB_STABLE - 1)) begin
        filt_d = sync2_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = db_en_i ? filt_q : sync2_q;
`else
  localparam int unused_db_stable = DB_STABLE;
  logic unused_db;
  assign unused_db = db_en_i ^ tick_i;
  assign filt_o    = sync2_q;
`endif

  assign rise  = filt_o & ~prev_q & ~dir_i;
  assign fall  = ~filt_o & prev_q & ~dir_i;
  assign lvl   = (pol_i ? filt_o : ~filt_o) & ~dir_i;
  assign edg   = both_i ? (rise | fall) : (pol_i ? rise : fall);
  assign hit_o = type_i ? lvl : edg;
endmodule

module apbgpio_pro #(
  parameter int GPIO_W    = 32,
  parameter int DB_STABLE = 4
) (
  input  logic              clk,
  input  logic              rst,
  apbgpio_pro_if.slave      apb,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              gpio_irq,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe
);
  localparam logic [7:0] A_DOUT = 8'h00, A_DIR = 8'h04, A_DIN = 8'h08, A_TYPE = 8'h0C;
  localparam logic [7:0] A_POL  = 8'h10, A_BOTH = 8'h14, A_ENB = 8'h18, A_STS = 8'h1C;
  localparam logic [7:0] A_SET  = 8'h20, A_CLR = 8'h24, A_TGL = 8'h28;
  localparam logic [7:0] A_DBE  = 8'h2C, A_DBP = 8'h30;

  logic              wr, rd;
  logic [7:0]        addr;
  logic [GPIO_W-1:0] wd;
  logic [GPIO_W-1:0] dout_q, dout_d, dir_q, dir_d, type_q, type_d;
  logic [GPIO_W-1:0] pol_q, pol_d, both_q, both_d, enb_q, enb_d, sts_q, sts_d;
  logic [GPIO_W-1:0] filt, hit, din, db_enb, w1c;
  logic              tick;
  logic [31:0]       rdata;
  logic              unused_bus;

  assign wr   = apb.psel & apb.penable & apb.pwrite;
  assign rd   = apb.psel & apb.penable & ~apb.pwrite;
  assign addr = apb.paddr[7:0];
  assign wd   = apb.pwdata[GPIO_W-1:0];
  assign unused_bus = ^{apb.paddr, apb.pwdata};

  assign w1c = (wr && addr == A_STS) ? wd : '0;

  always_comb begin
    dout_d = dout_q;
    dir_d  = dir_q;
    type_d = type_q;
    pol_d  = pol_q;
    both_d = both_q;
    enb_d  = enb_q;
    if (wr) begin
      case (addr)
        A_DOUT:  dout_d = wd;
        A_SET:   dout_d = dout_q | wd;
        A_CLR:   dout_d = dout_q & ~wd;
        A_TGL:   dout_d = dout_q ^ wd;
        A_DIR:   dir_d  = wd;
        A_TYPE:  type_d = wd;
        A_POL:   pol_d  = wd;
        A_BOTH:  both_d = wd;
        A_ENB:   enb_d  = wd;
        default: ;
      endcase
    end
    // a hit in the same cycle as the W1C keeps the bit set
    sts_d = (sts_q & ~w1c) | hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      dir_q  <= '0;
      type_q <= '0;
      pol_q  <= '0;
      both_q <= '0;
      enb_q  <= '0;
      sts_q  <= '0;
    end else begin
      dout_q <= dout_d;
      dir_q  <= dir_d;
      type_q <= type_d;
      pol_q  <= pol_d;
      both_q <= both_d;
      enb_q  <= enb_d;
      sts_q  <= sts_d;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  logic [GPIO_W-1:0] dbe_q, dbe_d;
  logic [15:0]       dbp_q, dbp_d, presc_q, presc_d;

  assign tick = (presc_q == dbp_q);

  always_comb begin
    dbe_d   = dbe_q;
    dbp_d   = dbp_q;
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    if (wr && addr == A_DBE) dbe_d = wd;
    if (wr && addr == A_DBP) begin
      dbp_d   = apb.pwdata[15:0];
      presc_d = 16'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbe_q   <= '0;
      dbp_q   <= '0;
      presc_q <= '0;
    end else begin
      dbe_q   <= dbe_d;
      dbp_q   <= dbp_d;
      presc_q <= presc_d;
    end
  end

  assign db_enb = dbe_q;
`else
  assign db_enb = '0;
  assign tick   = 1'b0;
`endif

  for (genvar i = 0; i < GPIO_W; i++) begin : g_pin
    apbgpio_pro_pin #(.DB_STABLE(DB_STABLE)) u_pin (
      .clk     (clk),
      .rst     (rst),
      .pad_i   (gpio_in[i]),
      .dir_i   (dir_q[i]),
      .type_i  (type_q[i]),
      .pol_i   (pol_q[i]),
      .both_i  (both_q[i]),
      .db_en_i (db_enb[i]),
      .tick_i  (tick),
      .filt_o  (filt[i]),
      .hit_o   (hit[i])
    );
  end

  assign din = filt & ~dir_q;

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (addr)
        A_DOUT:  rdata[GPIO_W-1:0] = dout_q;
        A_DIR:   rdata[GPIO_W-1:0] = dir_q;
        A_DIN:   rdata[GPIO_W-1:0] = din;
        A_TYPE:  rdata[GPIO_W-1:0] = type_q;
        A_POL:   rdata[GPIO_W-1:0] = pol_q;
        A_BOTH:  rdata[GPIO_W-1:0] = both_q;
        A_ENB:   rdata[GPIO_W-1:0] = enb_q;
        A_STS:   rdata[GPIO_W-1:0] = sts_q;
`ifdef GPIO_DEBOUNCE_EN
        A_DBE:   rdata[GPIO_W-1:0] = dbe_q;
        A_DBP:   rdata[15:0]       = dbp_q;
`endif
        default: rdata = '0;
      endcase
    end
  end

  assign apb.prdata = rdata;
  assign gpio_out   = dout_q;
  assign gpio_oe    = dir_q;
  assign gpio_irq   = |(sts_q & enb_q);
endmodule
